// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the maze generator and its solver.
//   state_t      - generator FSM states
//   LEFT..UP     - direction codes, shared with the wall-follower solver
//   LFSR_MASK    - Galois feedback mask of the 16-bit LFSR
//   LFSR_SEED_DEFAULT - substitute seed when a zero seed is supplied
//   galois_step  - one LFSR shift
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    START,
    PICK,
    CARVE,
    OPEN,
    DONE
  } state_t;

  localparam logic [1:0] LEFT  = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] DOWN  = 2'd2;
  localparam logic [1:0] UP    = 2'd3;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] galois_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// maze_lfsr: 16-bit Galois LFSR used to randomise the carve direction.
// Ports:
//   clk  - clock
//   load - load seed (zero seed is replaced by LFSR_SEED_DEFAULT); wins over en
//   en   - advance one step
//   seed - seed value
//   q    - current LFSR state
// The register carries no reset: it is always loaded before it is used.
module maze_lfsr
  import maze_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
    end else if (en) begin
      q <= galois_step(q);
    end
  end

endmodule

// File: rtl/maze_generator.sv
// maze_generator: randomised depth-first (recursive backtracker) perfect-maze
// generator with a hardware stack and LFSR-driven direction choice.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (maze all walls, idle, stack empty)
//   start - single-cycle generate request, accepted in IDLE or DONE
//   seed  - LFSR seed sampled on an accepted start (0 selects 16'hACE1)
//   step  - advance enable for PICK/CARVE/OPEN (only with MAZE_GEN_STEP_EN)
//   busy  - high while generating
//   done  - high from completion until the next accepted start or reset
//   maze  - maze image, maze[y][x], 1 = wall; row 0 has the entrance,
//           row size-1 the exit
// Configuration macro: MAZE_GEN_STEP_EN adds the step input so carving can be
// paced for visualisation. Without it the block advances every cycle.
// Latency from accepted start to done=1 is 3C+2 cycles, C = ((size-1)/2)^2.
module maze_generator
  import maze_pkg::*;
#(
  parameter int size  = 9,
  parameter int N     = 4,
  parameter int DEPTH = ((size - 1) / 2) * ((size - 1) / 2)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                seed,
`ifdef MAZE_GEN_STEP_EN
  input  logic                       step,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [size-1:0][size-1:0]  maze
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HI  = size - 2;

  typedef logic [N-1:0] crd_t;

  state_t          state, state_nxt;
  logic [2*N-1:0]  stack [DEPTH];
  logic [SPW-1:0]  sp;
  logic [AW-1:0]   top_idx, push_idx;
  logic [1:0]      dir;
  logic [15:0]     lfsr;
  logic            adv, accept, lfsr_en;
  crd_t            cx, cy, wx, wy, nx, ny;
  logic [3:0]      avail, rot;
  logic [1:0]      pick_dir;

`ifdef MAZE_GEN_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign busy    = (state == INIT) || (state == START) || (state == PICK) ||
                   (state == CARVE) || (state == OPEN);
  assign done    = (state == DONE);
  assign accept  = start && ((state == IDLE) || (state == DONE));
  // INIT and START always advance; the carving states are paced by adv.
  assign lfsr_en = busy && ((state == INIT) || (state == START) || adv);

  maze_lfsr u_lfsr (
    .clk  (clk),
    .load (accept),
    .en   (lfsr_en),
    .seed (seed),
    .q    (lfsr)
  );

  // sp counts entries; the top entry sits one below it.
  assign top_idx  = AW'(sp - SPW'(1));
  assign push_idx = AW'(sp);

  // Unvisited-neighbour mask of the top-of-stack cell and the randomised pick.
  always_comb begin
    {cy, cx} = stack[top_idx];
    avail        = '0;
    avail[LEFT]  = (cx >= crd_t'(3))    && maze[cy][cx - crd_t'(2)];
    avail[RIGHT] = (int'(cx) <= HI - 2) && maze[cy][cx + crd_t'(2)];
    avail[DOWN]  = (int'(cy) <= HI - 2) && maze[cy + crd_t'(2)][cx];
    avail[UP]    = (cy >= crd_t'(3))    && maze[cy - crd_t'(2)][cx];
    // Rotating right by lfsr[1:0] makes the lowest-set-bit search start at a
    // random direction; adding the rotation back recovers the direction.
    rot = '0;
    for (int j = 0; j < 4; j++) begin
      rot[j] = avail[2'(j) + lfsr[1:0]];
    end
    pick_dir = lfsr[1:0];
    for (int j = 3; j >= 0; j--) begin
      if (rot[j]) pick_dir = 2'(j) + lfsr[1:0];
    end
  end

  // Wall cell and neighbour cell for the direction chosen in PICK.
  always_comb begin
    wx = cx;
    wy = cy;
    nx = cx;
    ny = cy;
    case (dir)
      LEFT:    begin wx = cx - crd_t'(1); nx = cx - crd_t'(2); end
      RIGHT:   begin wx = cx + crd_t'(1); nx = cx + crd_t'(2); end
      DOWN:    begin wy = cy + crd_t'(1); ny = cy + crd_t'(2); end
      default: begin wy = cy - crd_t'(1); ny = cy - crd_t'(2); end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = START;
      START:   state_nxt = PICK;
      PICK: begin
        if (adv) begin
          if (avail != 4'b0000)    state_nxt = CARVE;
          else if (sp == SPW'(1))  state_nxt = OPEN;
        end
      end
      CARVE:   if (adv) state_nxt = PICK;
      OPEN:    if (adv) state_nxt = DONE;
      DONE:    if (start) state_nxt = INIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      maze <= '1;
      sp   <= '0;
    end else begin
      case (state)
        INIT: begin
          maze <= '1;
          sp   <= '0;
        end
        START: begin
          maze[1][1] <= 1'b0;
          sp         <= SPW'(1);
        end
        PICK: begin
          if (adv && (avail == 4'b0000)) sp <= sp - SPW'(1);
        end
        CARVE: begin
          if (adv) begin
            maze[wy][wx] <= 1'b0;
            maze[ny][nx] <= 1'b0;
            sp           <= sp + SPW'(1);
          end
        end
        OPEN: begin
          if (adv) begin
            maze[0][1]           <= 1'b0;
            maze[size-1][size-2] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack contents and the chosen direction are pure data; sp guards them.
  always_ff @(posedge clk) begin
    if (state == START) begin
      stack[0] <= {crd_t'(1), crd_t'(1)};
    end else if ((state == CARVE) && adv) begin
      stack[push_idx] <= {ny, nx};
    end
    if ((state == PICK) && adv) dir <= pick_dir;
  end

endmodule

// File: tb/tb_maze_generator.sv
// tb_maze_generator: randomized self-checking bench for maze_generator.
// A behavioural model replays the backtracker on arrays/queues, advancing its
// own copy of the LFSR once per generator cycle, and predicts the exact maze.
// Structural properties (borders, cells, wall count, BFS connectivity) are
// checked independently of the model.
module tb_maze_generator;

  localparam int SZ = 9;
  localparam int C  = ((SZ - 1) / 2) * ((SZ - 1) / 2);
  localparam int LAT = 3 * C + 2;
  localparam logic [127:0] ALL1 = (128'(1) << (SZ * SZ)) - 128'(1);

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [15:0]             seed;
  logic                    busy, done;
  logic [SZ-1:0][SZ-1:0]   maze_o;
`ifdef MAZE_GEN_STEP_EN
  logic                    step = 1'b1;
  bit                      step_toggle = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  maze_generator #(.size(SZ), .N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
`ifdef MAZE_GEN_STEP_EN
    .step  (step),
`endif
    .busy  (busy),
    .done  (done),
    .maze  (maze_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference backtracker. One LFSR step per generator cycle: INIT, START,
  // then every PICK and every CARVE.
  function automatic logic [SZ*SZ-1:0] ref_maze(input logic [15:0] sd);
    bit m [SZ][SZ];
    int sx[$], sy[$];
    int dx[4], dy[4];
    int x, y, r, d, c, tx, ty;
    logic [15:0] l;
    logic [SZ*SZ-1:0] img;
    dx = '{-2, 2, 0, 0};
    dy = '{0, 0, 2, -2};
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    l = lfsr_next(lfsr_next(l));
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) m[i][j] = 1'b1;
    m[1][1] = 1'b0;
    sx.push_back(1);
    sy.push_back(1);
    while (sx.size() > 0) begin
      x = sx[$];
      y = sy[$];
      r = int'(l[1:0]);
      d = -1;
      for (int k = 0; k < 4; k++) begin
        c  = (r + k) % 4;
        tx = x + dx[c];
        ty = y + dy[c];
        if (d < 0 && tx >= 1 && tx <= SZ - 2 && ty >= 1 && ty <= SZ - 2 && m[ty][tx]) d = c;
      end
      l = lfsr_next(l);
      if (d < 0) begin
        void'(sx.pop_back());
        void'(sy.pop_back());
      end else begin
        m[y + dy[d] / 2][x + dx[d] / 2] = 1'b0;
        m[y + dy[d]][x + dx[d]] = 1'b0;
        sx.push_back(x + dx[d]);
        sy.push_back(y + dy[d]);
        l = lfsr_next(l);
      end
    end
    m[0][1] = 1'b0;
    m[SZ-1][SZ-2] = 1'b0;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) img[i * SZ + j] = m[i][j];
    return img;
  endfunction

  function automatic int struct_errors(input logic [SZ*SZ-1:0] img);
    int e;
    logic v, want;
    bit care;
    e = 0;
    for (int y = 0; y < SZ; y++) begin
      for (int x = 0; x < SZ; x++) begin
        v = img[y * SZ + x];
        care = 1'b1;
        want = 1'b1;
        if ((y == 0 && x == 1) || (y == SZ - 1 && x == SZ - 2)) want = 1'b0;
        else if (y == 0 || x == 0 || y == SZ - 1 || x == SZ - 1) want = 1'b1;
        else if ((x % 2 == 1) && (y % 2 == 1)) want = 1'b0;
        else if ((x % 2 == 0) && (y % 2 == 0)) want = 1'b1;
        else care = 1'b0;
        if (care && v !== want) e++;
      end
    end
    return e;
  endfunction

  function automatic int open_walls(input logic [SZ*SZ-1:0] img);
    int n;
    n = 0;
    for (int y = 1; y < SZ - 1; y++)
      for (int x = 1; x < SZ - 1; x++)
        if (((x + y) % 2 == 1) && img[y * SZ + x] == 1'b0) n++;
    return n;
  endfunction

  function automatic int bfs_cells(input logic [SZ*SZ-1:0] img);
    bit seen [SZ][SZ];
    int qx[$], qy[$];
    int dx[4], dy[4];
    int cnt, x, y, tx, ty;
    dx = '{1, -1, 0, 0};
    dy = '{0, 0, 1, -1};
    cnt = 0;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) seen[i][j] = 1'b0;
    seen[1][1] = 1'b1;
    qx.push_back(1);
    qy.push_back(1);
    while (qx.size() > 0) begin
      x = qx.pop_front();
      y = qy.pop_front();
      if ((x % 2 == 1) && (y % 2 == 1)) cnt++;
      for (int k = 0; k < 4; k++) begin
        tx = x + dx[k];
        ty = y + dy[k];
        if (tx >= 1 && tx <= SZ - 2 && ty >= 1 && ty <= SZ - 2 && !seen[ty][tx] &&
            img[ty * SZ + tx] == 1'b0) begin
          seen[ty][tx] = 1'b1;
          qx.push_back(tx);
          qy.push_back(ty);
        end
      end
    end
    return cnt;
  endfunction

  // Step level for the upcoming edge e (accept edge is e=1).
  function automatic logic step_for(input int e);
`ifdef MAZE_GEN_STEP_EN
    return step_toggle ? logic'(e % 2 == 0) : 1'b1;
`else
    return logic'(e >= 0);
`endif
  endfunction

  // Issue a start and wait for done. poke>0 pulses start again (with a
  // different seed) that many cycles in. lat = cycle of first done, -1 on timeout.
  task automatic run_gen(input logic [15:0] sd, input int poke,
                         output int lat, output logic done_after_accept);
    int cyc;
    seed  = sd;
    start = 1'b1;
`ifdef MAZE_GEN_STEP_EN
    step = step_for(1);
`endif
    tick();
    start = 1'b0;
    seed  = ~sd;
    done_after_accept = done;
    cyc = 1;
    while (!done && cyc < 400) begin
      start = (cyc == poke);
`ifdef MAZE_GEN_STEP_EN
      step = step_for(cyc + 1);
`endif
      tick();
      cyc++;
    end
    start = 1'b0;
`ifdef MAZE_GEN_STEP_EN
    step = 1'b1;
`endif
    lat = done ? cyc : -1;
  endtask

  task automatic check_maze(input string tag, input logic [15:0] sd, input int lat, input int exp_lat);
    logic [SZ*SZ-1:0] img;
    img = maze_o;
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " busy"}, 128'(busy), 128'(0));
    check({tag, " image"}, 128'(img), 128'(ref_maze(sd)));
    check({tag, " entrance"}, 128'(img[0 * SZ + 1]), 128'(0));
    check({tag, " exit"}, 128'(img[(SZ - 1) * SZ + SZ - 2]), 128'(0));
    check({tag, " structure"}, 128'(struct_errors(img)), 128'(0));
    check({tag, " walls"}, 128'(open_walls(img)), 128'(C - 1));
    check({tag, " reach"}, 128'(bfs_cells(img)), 128'(C));
  endtask

  initial begin
    int lat;
    logic da;
    logic [SZ*SZ-1:0] m_a, m_b;
    logic [15:0] rs;

    rst = 1'b1;
    start = 1'b0;
    seed = 16'h0000;
    tick();
    tick();
    check("reset maze", 128'(maze_o), ALL1);
    check("reset busy", 128'(busy), 128'(0));
    check("reset done", 128'(done), 128'(0));
    rst = 1'b0;
    tick();

    // Basic generation
    run_gen(16'h0001, 0, lat, da);
    check("basic busy after accept", 128'(busy), 128'(0));
    check_maze("basic", 16'h0001, lat, LAT);

    // Restart from DONE
    run_gen(16'h0002, 0, lat, da);
    check("restart done drops", 128'(da), 128'(0));
    check_maze("restart", 16'h0002, lat, LAT);

    // Reproducibility
    run_gen(16'h1234, 0, lat, da);
    m_a = maze_o;
    run_gen(16'h1234, 0, lat, da);
    m_b = maze_o;
    check("repeat seed same", 128'(m_b), 128'(m_a));
    run_gen(16'h4321, 0, lat, da);
    check("other seed differs", 128'(maze_o != m_a), 128'(1));
    run_gen(16'h0000, 0, lat, da);
    m_a = maze_o;
    run_gen(16'hACE1, 0, lat, da);
    check("zero seed default", 128'(m_a), 128'(maze_o));
    check_maze("seed ace1", 16'hACE1, lat, LAT);

    // start while busy is ignored
    run_gen(16'h5A5A, 5, lat, da);
    check_maze("start busy", 16'h5A5A, lat, LAT);

    // Reset mid-generation
    seed = 16'h0777;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst maze", 128'(maze_o), ALL1);
    check("midrst busy", 128'(busy), 128'(0));
    check("midrst done", 128'(done), 128'(0));
    rst = 1'b0;
    tick();
    run_gen(16'h0001, 0, lat, da);
    check_maze("after midrst", 16'h0001, lat, LAT);

    // Randomized seeds against the model
    for (int t = 0; t < 6; t++) begin
      rs = 16'($urandom);
      run_gen(rs, 0, lat, da);
      check_maze("random", rs, lat, LAT);
    end

`ifdef MAZE_GEN_STEP_EN
    begin
      int exp_lat, e, n;
      step_toggle = 1'b1;
      e = 3;
      n = 0;
      while (n < 3 * C - 1) begin
        e++;
        if (step_for(e)) n++;
      end
      exp_lat = e;
      run_gen(16'h0001, 0, lat, da);
      check_maze("stepped", 16'h0001, lat, exp_lat);
      step_toggle = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
